// File: rtl/cmul_pkg.sv
// Shared widths, field packing and helpers for the complex-multiplier arbiter,
// its multiplier core and its testbench.
package cmul_pkg;

  localparam int unsigned CMUL_DW = 16;
  localparam int unsigned OPW     = 4 * CMUL_DW;
  localparam int unsigned PW      = 2 * CMUL_DW + 1;
  localparam int unsigned RESW    = 2 * PW;

  // Field order of one requester slice of req_data and of mul_op_data (MSB first).
  typedef struct packed {
    logic signed [CMUL_DW-1:0] a_re;
    logic signed [CMUL_DW-1:0] a_im;
    logic signed [CMUL_DW-1:0] b_re;
    logic signed [CMUL_DW-1:0] b_im;
  } cmul_op_t;

  // Field order of mul_res_data and rsp_data (MSB first).
  typedef struct packed {
    logic signed [PW-1:0] p_re;
    logic signed [PW-1:0] p_im;
  } cmul_res_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: rdata_o presents the head entry whenever empty_o is low.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset; entries are only visible once pushed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/cmul_arbiter.sv
// Round-robin scheduler sharing one pipelined complex multiplier among NREQ requesters,
// returning tagged results in issue order through a credit-limited result FIFO.
module cmul_arbiter
  import cmul_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DW    = CMUL_DW,
  parameter int unsigned LAT   = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*4*DW-1:0]        req_data,
  output logic                        mul_op_valid,
  output logic [4*DW-1:0]             mul_op_data,
  input  logic                        mul_res_valid,
  input  logic [2*(2*DW+1)-1:0]       mul_res_data,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [id_width(NREQ)-1:0]   rsp_id,
  output logic [2*(2*DW+1)-1:0]       rsp_data,
  output logic                        err_unexp
);

  localparam int unsigned IdW  = id_width(NREQ);
  localparam int unsigned OpW  = 4 * DW;
  localparam int unsigned ResW = 2 * (2 * DW + 1);
  localparam int unsigned RfW  = IdW + ResW;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned BlkW = $clog2(LAT + 1);

  logic [IdW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BlkW-1:0] blank_q, blank_d;
  logic            err_q, err_d;
  logic            op_valid_q, op_valid_d;
  logic [OpW-1:0]  op_data_q, op_data_d;

  logic [OpW-1:0]  req_ops [NREQ];
  logic [NREQ-1:0] vshift;
  int unsigned     cand;
  logic            gnt_any, issue_ok, gnt_fire, rsp_fire;
  logic [IdW-1:0]  gnt_idx;

  logic            res_live, id_pop, id_empty, id_full;
  logic [IdW-1:0]  id_head;
  logic [RfW-1:0]  rf_head;
  logic            rf_empty, rf_full;
  logic            unused_full;

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign req_ops[g] = req_data[g*OpW +: OpW];
  end

  // First valid requester searching upward from ptr_q + 1, wrapping at NREQ.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    vshift  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand   = (32'(ptr_q) + k) % NREQ;
      vshift = req_valid >> cand;
      if (!gnt_any && vshift[0]) begin
        gnt_any = 1'b1;
        gnt_idx = IdW'(cand);
      end
    end
  end

  assign issue_ok  = !rst && (cnt_q < CntW'(DEPTH));
  assign gnt_fire  = issue_ok && gnt_any;
  assign req_ready = gnt_fire ? (NREQ'(1) << gnt_idx) : '0;
  assign rsp_fire  = rsp_valid && rsp_ready;

  // Results landing during the post-reset blanking window belong to pre-reset issues.
  assign res_live = mul_res_valid && (blank_q == '0);
  assign id_pop   = res_live && !id_empty;

  always_comb begin
    ptr_d      = gnt_fire ? gnt_idx : ptr_q;
    op_valid_d = gnt_fire;
    op_data_d  = gnt_fire ? req_ops[gnt_idx] : op_data_q;
    blank_d    = (blank_q != '0) ? blank_q - BlkW'(1) : blank_q;
    err_d      = err_q || (res_live && id_empty);
    unique case ({gnt_fire, rsp_fire})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= IdW'(NREQ - 1);
      cnt_q      <= '0;
      blank_q    <= BlkW'(LAT);
      err_q      <= 1'b0;
      op_valid_q <= 1'b0;
      op_data_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      blank_q    <= blank_d;
      err_q      <= err_d;
      op_valid_q <= op_valid_d;
      op_data_q  <= op_data_d;
    end
  end

  sync_fifo #(
    .Width (IdW),
    .Depth (DEPTH)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (gnt_fire),
    .wdata_i (gnt_idx),
    .pop_i   (id_pop),
    .rdata_o (id_head),
    .full_o  (id_full),
    .empty_o (id_empty)
  );

  sync_fifo #(
    .Width (RfW),
    .Depth (DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (id_pop),
    .wdata_i ({id_head, mul_res_data}),
    .pop_i   (rsp_fire),
    .rdata_o (rf_head),
    .full_o  (rf_full),
    .empty_o (rf_empty)
  );

  // Credits bound both FIFOs, so their full flags never gate anything.
  assign unused_full = id_full ^ rf_full;

  assign mul_op_valid = op_valid_q;
  assign mul_op_data  = op_data_q;
  assign rsp_valid    = !rf_empty;
  assign rsp_id       = rsp_valid ? rf_head[RfW-1 -: IdW] : '0;
  assign rsp_data     = rsp_valid ? rf_head[ResW-1:0] : '0;
  assign err_unexp    = err_q;

endmodule

// File: tb/tb_cmul_arbiter.sv
// Scoreboard bench for cmul_arbiter with a behavioural LAT-stage complex multiplier.
module tb_cmul_arbiter;
  import cmul_pkg::*;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned DW    = CMUL_DW;
  localparam int unsigned LAT   = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IdW   = id_width(NREQ);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OPW-1:0] req_data = '0;
  logic                mul_op_valid;
  logic [OPW-1:0]      mul_op_data;
  logic                mul_res_valid;
  logic [RESW-1:0]     mul_res_data;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [IdW-1:0]      rsp_id;
  logic [RESW-1:0]     rsp_data;
  logic                err_unexp;
  logic                inj_res = 1'b0;

  int checks = 0;
  int errors = 0;
  int gnt_cnt = 0;
  int exp_gnt[$];
  logic [IdW+RESW-1:0] sb[$];

  always #5 clk = ~clk;

  cmul_arbiter #(
    .NREQ  (NREQ),
    .DW    (DW),
    .LAT   (LAT),
    .DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_data      (req_data),
    .mul_op_valid  (mul_op_valid),
    .mul_op_data   (mul_op_data),
    .mul_res_valid (mul_res_valid),
    .mul_res_data  (mul_res_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .err_unexp     (err_unexp)
  );

  // Multiplier model: never reset, so in-flight work survives a DUT reset.
  cmul_op_t        mop;
  cmul_res_t       mprod;
  logic [LAT-1:0]  pv_q = '0;
  cmul_res_t       pd_q [LAT];

  assign mop = mul_op_data;
  always_comb begin
    mprod.p_re = PW'(longint'(mop.a_re) * longint'(mop.b_re) - longint'(mop.a_im) * longint'(mop.b_im));
    mprod.p_im = PW'(longint'(mop.a_re) * longint'(mop.b_im) + longint'(mop.a_im) * longint'(mop.b_re));
  end
  always @(posedge clk) begin
    pv_q     <= {pv_q[LAT-2:0], mul_op_valid};
    pd_q[0]  <= mprod;
    for (int k = 1; k < LAT; k++) pd_q[k] <= pd_q[k-1];
  end
  assign mul_res_valid = pv_q[LAT-1] | inj_res;
  assign mul_res_data  = pd_q[LAT-1];

  function automatic cmul_op_t op_of(input int i);
    case (i)
      0:       op_of = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
      1:       op_of = '{16'sd2, -16'sd1, 16'sd2, 16'sd1};
      2:       op_of = '{16'sd3, 16'sd4, 16'sd1, -16'sd2};
      default: op_of = '{-16'sd2, 16'sd3, -16'sd1, -16'sd1};
    endcase
  endfunction

  // Hand-computed products of op_of(i).
  function automatic cmul_res_t exp_res(input int i);
    case (i)
      0:       exp_res = '{-33'sd5, 33'sd10};
      1:       exp_res = '{33'sd5, 33'sd0};
      2:       exp_res = '{33'sd11, -33'sd2};
      default: exp_res = '{33'sd5, -33'sd1};
    endcase
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    inj_res   = 1'b0;
    cyc(2);
    exp_gnt.delete();
    sb.delete();
    rst = 1'b0;
    cyc(LAT + 2);
  endtask

  task automatic wait_grants(input int n);
    int base;
    base = gnt_cnt;
    for (int k = 0; k < 200 && (gnt_cnt - base) < n; k++) cyc(1);
    chk("grant_count", gnt_cnt - base, n);
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int k = 0; k < 100 && (sb.size() != 0 || exp_gnt.size() != 0); k++) cyc(1);
    chk("drain_sb", sb.size(), 0);
    chk("drain_gnt", exp_gnt.size(), 0);
  endtask

  // Monitor: grants generate expectations, response handshakes consume them.
  initial begin
    int g;
    logic [IdW+RESW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && (req_valid & req_ready) != '0) begin
        gnt_cnt++;
        chk("grant_expected", exp_gnt.size() != 0, 1);
        if (exp_gnt.size() != 0) begin
          g = exp_gnt.pop_front();
          chk("grant_onehot", req_ready, 128'(1) << g);
          sb.push_back({IdW'(g), exp_res(g)});
        end
      end
      if (!rst && rsp_valid && rsp_ready) begin
        chk("rsp_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("rsp_id", rsp_id, e[IdW+RESW-1 -: IdW]);
          chk("rsp_data", rsp_data, e[RESW-1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) req_data[i*OPW +: OPW] = op_of(i);

    // Reset values, with requests pending to show the grant is held off.
    req_valid = '1;
    rsp_ready = 1'b1;
    cyc(2);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_op_valid", mul_op_valid, 0);
    chk("rst_op_data", mul_op_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_err", err_unexp, 0);
    do_reset();

    // Single op from requester 2: (3+4j)(1-2j) = 11-2j.
    rsp_ready = 1'b1;
    exp_gnt.push_back(2);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("single_ready", req_ready, 4'b0100);
    cyc(1);
    req_valid = '0;
    @(negedge clk);
    chk("single_op_valid", mul_op_valid, 1);
    chk("single_op_data", mul_op_data, op_of(2));
    cyc(3);
    @(negedge clk);
    chk("single_rsp_early", rsp_valid, 0);
    cyc(1);
    @(negedge clk);
    chk("single_rsp_t5", rsp_valid, 1);
    cyc(1);
    drain();

    // Fairness: all requesters valid, round-robin from requester 0.
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_gnt.push_back(i % NREQ);
    req_valid = '1;
    wait_grants(8);
    req_valid = '0;
    drain();

    // Backpressure: credits run out after DEPTH grants.
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_gnt.push_back(i);
    req_valid = '1;
    begin
      int base;
      base = gnt_cnt;
      cyc(12);
      chk("bp_grants", gnt_cnt - base, 4);
      @(negedge clk);
      chk("bp_ready_low", req_ready, 0);
      cyc(1);
      rsp_ready = 1'b1;
      exp_gnt.push_back(0);
      @(negedge clk);
      chk("bp_same_cycle", req_ready, 0);
      chk("bp_rsp_valid", rsp_valid, 1);
      cyc(1);
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("bp_regrant", req_ready, 4'b0001);
      cyc(1);
      @(negedge clk);
      chk("bp_full_again", req_ready, 0);
      cyc(3);
      chk("bp_total", gnt_cnt - base, 5);
    end
    req_valid = '0;
    drain();

    // Issue and response in the same cycle at cnt = DEPTH-1.
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) exp_gnt.push_back(i);
    req_valid = '1;
    wait_grants(3);
    req_valid = '0;
    cyc(8);
    exp_gnt.push_back(3);
    exp_gnt.push_back(0);
    req_valid = '1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("sim_gnt", req_ready, 4'b1000);
    cyc(1);
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("sim_next_gnt", req_ready, 4'b0001);
    cyc(1);
    @(negedge clk);
    chk("sim_full", req_ready, 0);
    cyc(1);
    req_valid = '0;
    drain();

    // Unexpected result after blanking.
    do_reset();
    rsp_ready = 1'b1;
    inj_res = 1'b1;
    cyc(1);
    inj_res = 1'b0;
    @(negedge clk);
    chk("unexp_err", err_unexp, 1);
    chk("unexp_rsp", rsp_valid, 0);
    cyc(5);
    @(negedge clk);
    chk("unexp_sticky", err_unexp, 1);
    chk("unexp_rsp_later", rsp_valid, 0);

    // Reset with three operations in flight.
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) exp_gnt.push_back(i);
    req_valid = '1;
    wait_grants(3);
    req_valid = '0;
    rst = 1'b1;
    #2;
    exp_gnt.delete();
    sb.delete();
    rst = 1'b0;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      chk("midrst_rsp", rsp_valid, 0);
      chk("midrst_err", err_unexp, 0);
    end
    cyc(1);
    exp_gnt.push_back(1);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("midrst_new_gnt", req_ready, 4'b0010);
    cyc(1);
    req_valid = '0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
